// File: rtl/base_regfile.sv
// base_regfile: register bank behind the AXI4-Lite front end (ID, LEDs, switches, buttons, IRQ, scratch, aux reset).
// Optional button debounce is built when BASE_REGFILE_DEBOUNCE_EN is defined.
module base_regfile #(
    parameter int          P_ADDR_WIDTH      = 8,
    parameter int          P_DATA_WIDTH      = 32,
    parameter int          P_NUM_LED         = 8,
    parameter int          P_NUM_SWITCH      = 8,
    parameter int          P_NUM_BUTTON      = 5,
    parameter logic [31:0] P_ID_VALUE        = 32'hB45E_0001,
    parameter int          P_AUX_RST_CYCLES  = 16,
    parameter int          P_DEBOUNCE_CYCLES = 1000
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      wr_req,
    input  logic [P_ADDR_WIDTH-1:0]   wr_addr,
    input  logic [P_DATA_WIDTH-1:0]   wr_data,
    input  logic [P_DATA_WIDTH/8-1:0] wr_strb,
    output logic                      wr_ack,
    output logic [1:0]                wr_resp,
    input  logic                      rd_req,
    input  logic [P_ADDR_WIDTH-1:0]   rd_addr,
    output logic                      rd_valid,
    output logic [P_DATA_WIDTH-1:0]   rd_data,
    output logic [1:0]                rd_resp,
    input  logic [P_NUM_SWITCH-1:0]   switches,
    input  logic [P_NUM_BUTTON-1:0]   buttons,
    output logic [P_NUM_LED-1:0]      leds,
    output logic                      irq,
    output logic                      aux_resetn
);

    localparam int STRB_W = P_DATA_WIDTH / 8;
    localparam int CNT_W  = (P_AUX_RST_CYCLES > 1) ? $clog2(P_AUX_RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(P_AUX_RST_CYCLES - 1);
    localparam logic [31:0] IRQ_MASK = {15'd0, 1'b1, 16'((17'd1 << P_NUM_BUTTON) - 17'd1)};
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] A_ID = 3'd0, A_LED = 3'd1, A_SWITCH = 3'd2, A_BUTTON = 3'd3;
    localparam logic [2:0] A_IRQ_STATUS = 3'd4, A_IRQ_ENABLE = 3'd5, A_AUX = 3'd6, A_SCRATCH = 3'd7;

    function automatic logic [P_DATA_WIDTH-1:0] strb_mask(input logic [STRB_W-1:0] strb);
        logic [P_DATA_WIDTH-1:0] m;
        for (int b = 0; b < STRB_W; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

    function automatic logic [P_DATA_WIDTH-1:0] merge_bytes(input logic [P_DATA_WIDTH-1:0] old_v,
                                                            input logic [P_DATA_WIDTH-1:0] new_v,
                                                            input logic [P_DATA_WIDTH-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    typedef enum logic [0:0] {AUX_IDLE = 1'b0, AUX_PULSE = 1'b1} aux_state_e;

    logic [P_NUM_SWITCH-1:0] sw_meta_r, sw_sync_r, sw_prev_r;
    logic [P_NUM_BUTTON-1:0] btn_meta_r, btn_sync_r, btn_prev_r, btn_val_s;
    logic [P_NUM_LED-1:0]    led_r;
    logic [31:0]             scratch_r, irq_status_r, irq_en_r;
    logic [31:0]             wr_mask_s, irq_set_s, irq_clr_s, status_next_s, rd_mux_s;
    logic                    wr_mapped_s, rd_mapped_s, aux_trig_s;
    logic                    wr_ack_r, rd_valid_r, irq_r;
    logic [1:0]              wr_resp_r, rd_resp_r;
    logic [31:0]             rd_data_r;
    aux_state_e              aux_state_r, aux_state_next_s;
    logic [CNT_W-1:0]        aux_cnt_r, aux_cnt_next_s;
    logic                    aux_resetn_r, aux_resetn_next_s;
    logic                    unused_addr_s;

    assign unused_addr_s = ^{wr_addr[1:0], rd_addr[1:0]};
    assign wr_mapped_s   = (wr_addr[P_ADDR_WIDTH-1:5] == {(P_ADDR_WIDTH-5){1'b0}});
    assign rd_mapped_s   = (rd_addr[P_ADDR_WIDTH-1:5] == {(P_ADDR_WIDTH-5){1'b0}});
    assign wr_mask_s     = strb_mask(wr_strb);
    assign aux_trig_s    = wr_req && wr_mapped_s && (wr_addr[4:2] == A_AUX) && wr_strb[0] && wr_data[0];

    // Two-flop synchronisers plus the one-cycle-delayed copies used for edge/change detect
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            sw_meta_r  <= {P_NUM_SWITCH{1'b0}};
            sw_sync_r  <= {P_NUM_SWITCH{1'b0}};
            sw_prev_r  <= {P_NUM_SWITCH{1'b0}};
            btn_meta_r <= {P_NUM_BUTTON{1'b0}};
            btn_sync_r <= {P_NUM_BUTTON{1'b0}};
            btn_prev_r <= {P_NUM_BUTTON{1'b0}};
        end else begin
            sw_meta_r  <= switches;
            sw_sync_r  <= sw_meta_r;
            sw_prev_r  <= sw_sync_r;
            btn_meta_r <= buttons;
            btn_sync_r <= btn_meta_r;
            btn_prev_r <= btn_val_s;
        end
    end

`ifdef BASE_REGFILE_DEBOUNCE_EN
    localparam int DB_W = $clog2(P_DEBOUNCE_CYCLES + 1);
    logic [DB_W-1:0]         db_cnt_r [P_NUM_BUTTON];
    logic [P_NUM_BUTTON-1:0] btn_db_r;

    // Per-button stability counter; any bounce back to the debounced value restarts it
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            btn_db_r <= {P_NUM_BUTTON{1'b0}};
            for (int i = 0; i < P_NUM_BUTTON; i++) begin
                db_cnt_r[i] <= {DB_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < P_NUM_BUTTON; i++) begin
                if (btn_sync_r[i] != btn_db_r[i]) begin
                    if (db_cnt_r[i] == DB_W'(P_DEBOUNCE_CYCLES - 1)) begin
                        btn_db_r[i] <= btn_sync_r[i];
                        db_cnt_r[i] <= {DB_W{1'b0}};
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt_r[i] <= {DB_W{1'b0}};
                end
            end
        end
    end

    assign btn_val_s = btn_db_r;
`else
    localparam int unused_db_cycles_c = P_DEBOUNCE_CYCLES;
    assign btn_val_s = btn_sync_r;
`endif

    // Status update: sets from input events win over a simultaneous W1C
    always_comb begin
        irq_set_s = 32'(btn_val_s & ~btn_prev_r) | {15'd0, |(sw_sync_r ^ sw_prev_r), 16'd0};
        if (wr_req && wr_mapped_s && (wr_addr[4:2] == A_IRQ_STATUS)) begin
            irq_clr_s = wr_data & wr_mask_s;
        end else begin
            irq_clr_s = 32'd0;
        end
        status_next_s = ((irq_status_r & ~irq_clr_s) | irq_set_s) & IRQ_MASK;
    end

    // Writable registers
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            led_r        <= {P_NUM_LED{1'b0}};
            scratch_r    <= 32'd0;
            irq_en_r     <= 32'd0;
            irq_status_r <= 32'd0;
        end else begin
            irq_status_r <= status_next_s;
            if (wr_req && wr_mapped_s) begin
                case (wr_addr[4:2])
                    A_LED:        led_r <= (led_r & ~wr_mask_s[P_NUM_LED-1:0])
                                           | (wr_data[P_NUM_LED-1:0] & wr_mask_s[P_NUM_LED-1:0]);
                    A_IRQ_ENABLE: irq_en_r  <= merge_bytes(irq_en_r, wr_data, wr_mask_s) & IRQ_MASK;
                    A_SCRATCH:    scratch_r <= merge_bytes(scratch_r, wr_data, wr_mask_s);
                    default:      ;
                endcase
            end
        end
    end

    // Read mux; unmapped addresses return zero
    always_comb begin
        rd_mux_s = 32'd0;
        case (rd_addr[4:2])
            A_ID:         rd_mux_s = P_ID_VALUE;
            A_LED:        rd_mux_s = 32'(led_r);
            A_SWITCH:     rd_mux_s = 32'(sw_sync_r);
            A_BUTTON:     rd_mux_s = 32'(btn_val_s);
            A_IRQ_STATUS: rd_mux_s = irq_status_r;
            A_IRQ_ENABLE: rd_mux_s = irq_en_r;
            A_SCRATCH:    rd_mux_s = scratch_r;
            default:      rd_mux_s = 32'd0;
        endcase
        if (!rd_mapped_s) begin
            rd_mux_s = 32'd0;
        end else begin
            rd_mux_s = rd_mux_s;
        end
    end

    // Single-cycle responses and the registered interrupt
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ack_r   <= 1'b0;
            wr_resp_r  <= RESP_OKAY;
            rd_valid_r <= 1'b0;
            rd_data_r  <= 32'd0;
            rd_resp_r  <= RESP_OKAY;
            irq_r      <= 1'b0;
        end else begin
            wr_ack_r   <= wr_req;
            wr_resp_r  <= (wr_req && !wr_mapped_s) ? RESP_SLVERR : RESP_OKAY;
            rd_valid_r <= rd_req;
            rd_data_r  <= rd_req ? rd_mux_s : 32'd0;
            rd_resp_r  <= (rd_req && !rd_mapped_s) ? RESP_SLVERR : RESP_OKAY;
            irq_r      <= |(irq_status_r & irq_en_r);
        end
    end

    // Aux reset FSM: state register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aux_state_r  <= AUX_IDLE;
            aux_cnt_r    <= {CNT_W{1'b0}};
            aux_resetn_r <= 1'b1;
        end else begin
            aux_state_r  <= aux_state_next_s;
            aux_cnt_r    <= aux_cnt_next_s;
            aux_resetn_r <= aux_resetn_next_s;
        end
    end

    // Aux reset FSM: next state; a trigger during the pulse reloads the counter
    always_comb begin
        aux_state_next_s = aux_state_r;
        aux_cnt_next_s   = aux_cnt_r;
        case (aux_state_r)
            AUX_IDLE: begin
                if (aux_trig_s) begin
                    aux_state_next_s = AUX_PULSE;
                    aux_cnt_next_s   = CNT_LOAD;
                end else begin
                    aux_state_next_s = AUX_IDLE;
                end
            end
            AUX_PULSE: begin
                if (aux_trig_s) begin
                    aux_cnt_next_s = CNT_LOAD;
                end else if (aux_cnt_r == {CNT_W{1'b0}}) begin
                    aux_state_next_s = AUX_IDLE;
                end else begin
                    aux_cnt_next_s = aux_cnt_r - CNT_W'(1);
                end
            end
            default: begin
                aux_state_next_s = AUX_IDLE;
                aux_cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Aux reset FSM: output, low while pulsing
    always_comb begin
        aux_resetn_next_s = 1'b1;
        case (aux_state_next_s)
            AUX_PULSE: aux_resetn_next_s = 1'b0;
            default:   aux_resetn_next_s = 1'b1;
        endcase
    end

    assign wr_ack     = wr_ack_r;
    assign wr_resp    = wr_resp_r;
    assign rd_valid   = rd_valid_r;
    assign rd_data    = rd_data_r;
    assign rd_resp    = rd_resp_r;
    assign leds       = led_r;
    assign irq        = irq_r;
    assign aux_resetn = aux_resetn_r;

endmodule

// File: doc/base_regfile.md
Name: base_regfile

Overview:
- Register-bank stage directly downstream of the AXI4-Lite slave front end.
- Consumes decoded single-beat write and read requests and returns read data and responses.
- Owns the LED output, switch and button input synchronisers, the button/switch interrupt logic, and the self-clearing aux_resetn pulse generator.
- The front end only does AXI handshaking; all register semantics live here.

Parameters:
- P_ADDR_WIDTH, 8: byte address width of requests.
- P_DATA_WIDTH, 32: data width; fixed at 32, and the byte-strobe width is P_DATA_WIDTH/8.
- P_NUM_LED, 8: LED output count, max 32.
- P_NUM_SWITCH, 8: switch input count, max 16.
- P_NUM_BUTTON, 5: button input count, max 16.
- P_ID_VALUE, 32'hB45E_0001: constant returned by the ID register.
- P_AUX_RST_CYCLES, 16: low-pulse length of aux_resetn in ACLK cycles, min 1.
- P_DEBOUNCE_CYCLES, 1000: button stable count, used only with the optional feature.

Ports:
- ACLK, in, 1: the block's single clock.
- ARESET, in, 1: asynchronous, active-high reset.
- wr_req, in, 1: one-cycle write request strobe.
- wr_addr, in, P_ADDR_WIDTH: byte address of the write.
- wr_data, in, P_DATA_WIDTH: write data.
- wr_strb, in, P_DATA_WIDTH/8: byte-lane enables for the write.
- wr_ack, out, 1: write completion pulse.
- wr_resp, out, 2: 2'b00 OKAY, 2'b10 SLVERR; valid while wr_ack is high.
- rd_req, in, 1: one-cycle read request strobe.
- rd_addr, in, P_ADDR_WIDTH: byte address of the read.
- rd_valid, out, 1: read data valid pulse.
- rd_data, out, P_DATA_WIDTH: read data.
- rd_resp, out, 2: read response, same encoding as wr_resp.
- switches, in, P_NUM_SWITCH: asynchronous switch inputs.
- buttons, in, P_NUM_BUTTON: asynchronous button inputs.
- leds, out, P_NUM_LED: registered LED outputs.
- irq, out, 1: registered, level interrupt.
- aux_resetn, out, 1: active-low auxiliary reset output.

Behaviour:
- Reset values (asynchronous on ARESET):
  - wr_ack=0, wr_resp=0, rd_valid=0, rd_data=0, rd_resp=0, leds=0, irq=0, aux_resetn=1.
  - All registers and synchroniser flops = 0; the aux counter is idle.
- Request handling:
  - wr_req and rd_req may be asserted in the same cycle, or every cycle.
  - Latency is exactly 1 cycle. wr_req in cycle N gives wr_ack/wr_resp in cycle N+1; rd_req in cycle N gives rd_valid/rd_data/rd_resp in cycle N+1.
  - There is no backpressure and no queueing.
- Address decode:
  - Decode uses wr_addr/rd_addr[4:2]; bits [1:0] are ignored.
  - Any address >= 0x20 is unmapped. An unmapped write is ignored and returns SLVERR; an unmapped read returns rd_data=0 with SLVERR.
- Register map (byte offsets):
  - 0x00 ID: RO, returns P_ID_VALUE. Writes are ignored and return OKAY.
  - 0x04 LED: RW, bits [P_NUM_LED-1:0], per-byte strobe. leds is driven directly from this register.
  - 0x08 SWITCH: RO, synchronised switch value in bits [P_NUM_SWITCH-1:0].
  - 0x0C BUTTON: RO, synchronised (or debounced) button value in bits [P_NUM_BUTTON-1:0].
  - 0x10 IRQ_STATUS: W1C.
    - Bit i (i < P_NUM_BUTTON) sets on a rising edge of button i.
    - Bit 16 sets on any change of the synchronised switch vector.
    - A clear needs a 1 in the bit and the matching strobe byte.
  - 0x14 IRQ_ENABLE: RW, same bit layout as IRQ_STATUS; unused bits read 0.
  - 0x18 AUX_RESET: WO, reads 0.
    - A write with wr_strb[0]=1 and wr_data[0]=1 starts or restarts the pulse.
  - 0x1C SCRATCH: RW, 32 bits, per-byte strobe.
- Input path:
  - 2-flop synchroniser on every switch and button bit.
  - The edge/change detect compares the synchronised value with its 1-cycle-delayed copy.
  - Pin change to status bit set takes 3 cycles.
- Set/clear collision: if a status bit sets in the same cycle a W1C clears it, the set wins (the bit stays 1).
- irq: registered each cycle as irq <= |(IRQ_STATUS & IRQ_ENABLE), so it lags status by 1 cycle.
- Aux reset state machine, states IDLE and PULSE:
  - IDLE -> PULSE on a trigger write; the counter loads P_AUX_RST_CYCLES-1 and aux_resetn <= 0 on the next edge.
  - PULSE: the counter decrements each cycle. At count 0 the next edge sets aux_resetn <= 1 and goes to IDLE. The low time is exactly P_AUX_RST_CYCLES cycles.
  - A trigger in PULSE reloads the counter, extending the pulse.
  - ARESET mid-pulse returns the machine to IDLE with aux_resetn=1 immediately.
- ARESET mid-transaction drops any pending wr_ack/rd_valid; no response is produced for that request.

Optional Feature:
- Macro: BASE_REGFILE_DEBOUNCE_EN.
- Defined:
  - Each synchronised button passes through a per-bit counter.
  - The debounced value updates only after the input differs from it for P_DEBOUNCE_CYCLES consecutive cycles; any bounce resets the counter.
  - The BUTTON register and edge detect use the debounced value, so pin-to-status latency becomes P_DEBOUNCE_CYCLES+3.
- Undefined: no counters; the synchronised value is used directly, and P_DEBOUNCE_CYCLES is unused.

Test Plan:
- Write 0x04 = 0x000000A5, strb=4'hF -> wr_ack with OKAY the next cycle; leds=8'hA5. Read 0x04 -> rd_data=0xA5, OKAY, 1 cycle later.
- Read 0x00 and 0x24 in back-to-back cycles -> 0xB45E0001/OKAY, then 0/SLVERR. Write 0x24 -> SLVERR, no register changes.
- IRQ_ENABLE=0x1, raise buttons[0] -> status bit0 = 1 after 3 cycles, irq=1 one cycle later. W1C 0x10 with 0x1 -> status 0, irq 0.
- W1C of bit0 in the same cycle a new buttons[0] edge is detected -> status bit0 stays 1.
- Write 0x18 = 0x1 -> aux_resetn low for exactly 16 cycles. Retrigger at cycle 10 -> the low time extends to 26 cycles. ARESET at cycle 5 of a fresh pulse -> aux_resetn=1 immediately.
- SCRATCH: write 0xFFFFFFFF, then write 0x12345678 with strb=4'b0101 -> read returns 0xFF34FF78. With DEBOUNCE_EN and P_DEBOUNCE_CYCLES=4, a 3-cycle glitch on buttons[1] -> no status set.
